mips_cpu_memory_bus: RTL and testbench

- Behavioural, byte-addressed, little-endian RAM model with an Avalon-style read/write bus.
- Serves as instruction/data memory for the MIPS32 CPU in simulation benches.
- Supports unaligned byte addresses and per-lane byte enables.
- Read data returns only the enabled lanes, compacted toward the LSBs.

---
 rtl/mips_cpu_mem_pkg.sv | 15 +
 rtl/mips_cpu_memory_bus_if.sv | 25 ++
 rtl/mips_cpu_mem_lane_compact.sv | 23 ++
 rtl/mips_cpu_memory_bus.sv | 105 ++++++++++
 tb/tb_mips_cpu_memory_bus.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_mem_pkg.sv
// Shared widths and types for the MIPS32 behavioural memory bus model.
package mips_cpu_mem_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int DATA_W = 32;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_t;

endpackage

// File: rtl/mips_cpu_memory_bus_if.sv
// Avalon-style read/write bus between a MIPS32 CPU (master) and its memory (slave).
interface mips_cpu_memory_bus_if #(
    parameter int ADDR_W = 24
);
    import mips_cpu_mem_pkg::*;

    logic                read;
    logic                write;
    logic [LANES-1:0]    byteenable;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output read, write, byteenable, addr, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  read, write, byteenable, addr, writedata,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_cpu_mem_lane_compact.sv
// Packs the enabled byte lanes toward the LSBs in ascending lane order and zero-fills the rest.
module mips_cpu_mem_lane_compact
    import mips_cpu_mem_pkg::*;
(
    input  logic [LANES-1:0][BYTE_W-1:0] lane_bytes,
    input  logic [LANES-1:0]             byteenable,
    output logic [DATA_W-1:0]            word
);

    always_comb begin
        int unsigned k;
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        word = '0;
        k    = 0;
        for (int i = 0; i < LANES; i++) begin
            if (byteenable[i]) begin
                word[k*BYTE_W +: BYTE_W] = lane_bytes[i];
                k++;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_memory_bus.sv
// Byte-addressed little-endian RAM model on an Avalon-style bus for MIPS32 simulation.
// Define MIPS_CPU_MEMORY_BUS_WAITSTATE_EN to add one wait state to every access.
module mips_cpu_memory_bus
    import mips_cpu_mem_pkg::*;
#(
    parameter int    ADDR_W    = 24,
    parameter int    MEM_BYTES = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic                         clk,
    input  logic                         reset,
    mips_cpu_memory_bus_if.slave         bus
);

    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    byte_t                         mem [MEM_BYTES];
    logic [LANES-1:0][BYTE_W-1:0]  fetched;
    logic [DATA_W-1:0]             compacted;
    logic                          waitreq;
    logic                          do_write;
    logic                          do_read;

    // Byte index of addr+lane, reduced modulo MEM_BYTES so accesses wrap at the top.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a,
                                                  input int unsigned lane);
        logic [ADDR_W:0] s;
        s = {1'b0, a % ADDR_W'(MEM_BYTES)} + (ADDR_W+1)'(lane);
        if (s >= (ADDR_W+1)'(MEM_BYTES))
            s = s - (ADDR_W+1)'(MEM_BYTES);
        return s[IDX_W-1:0];
    endfunction

    // Contents start all-zero at time zero.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++)
            mem[i] = '0;
    end

`ifdef MIPS_CPU_MEMORY_BUS_WAITSTATE_EN
    wait_state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        waitreq    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.read || bus.write) begin
                    waitreq    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A stalled master must hold its request until the wait state ends.
    property p_hold_request;
        @(posedge clk) disable iff (reset)
        (state == ST_WAIT) |->
            $stable({bus.read, bus.write, bus.byteenable, bus.addr, bus.writedata});
    endproperty
    a_hold_request: assert property (p_hold_request);
`else
    assign waitreq = 1'b0;
`endif

    assign bus.waitrequest = waitreq;
    assign do_write        = bus.write && !waitreq;
    assign do_read         = bus.read && !bus.write && !waitreq;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            fetched[i] = mem[wrap_idx(bus.addr, i)];
    end

    mips_cpu_mem_lane_compact u_compact (
        .lane_bytes (fetched),
        .byteenable (bus.byteenable),
        .word       (compacted)
    );

    // NOTE: the storage array has no reset; its contents must survive a reset pulse.
    always @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.byteenable[i])
                    mem[wrap_idx(bus.addr, i)] <= bus.writedata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments to avoid ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        bus.readdata <= '0;
        else if (do_read) bus.readdata <= compacted;
    end

endmodule

// File: tb/tb_mips_cpu_memory_bus.sv
// Scoreboard bench for mips_cpu_memory_bus: directed accesses, monitor-side read checking.
module tb_mips_cpu_memory_bus;

    localparam int ADDR_W    = 24;
    localparam int MEM_BYTES = 4096;

    logic clk;
    logic reset;

    mips_cpu_memory_bus_if #(.ADDR_W(ADDR_W)) bus ();

    mips_cpu_memory_bus #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read accepted at a rising edge is compared just after that edge.
    always @(posedge clk) begin
        if (!reset && bus.read && !bus.write && !bus.waitrequest) begin
            #1;
            if (exp_q.size() == 0) begin
                check("unexpected_read", bus.readdata, 32'hxxxx_xxxx);
            end else begin
                mon_exp = exp_q.pop_front();
                check("readdata", bus.readdata, mon_exp);
            end
        end
    end

    task automatic bus_idle();
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.byteenable = '0;
        bus.addr       = '0;
        bus.writedata  = '0;
    endtask

    // Hold the request through any wait states, then drop it on the next falling edge.
    task automatic complete();
        int   n;
        logic stall;
        n = 0;
        do begin
            @(posedge clk);
            stall = bus.waitrequest;
            n++;
        end while (stall && n < 8);
        if (stall)
            check("wait_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        @(negedge clk);
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.addr       = a;
        bus.writedata  = d;
        bus.byteenable = be;
        complete();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [3:0] be,
                           input logic [31:0] exp);
        @(negedge clk);
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.addr       = a;
        bus.byteenable = be;
        exp_q.push_back(exp);
        complete();
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_read(24'd0, 4'b1111, 32'h0000_0000);

        do_write(24'd20, 32'h0000_ffff, 4'b1111);
        do_read (24'd20, 4'b1111, 32'h0000_ffff);

        do_write(24'd24, 32'h0000_ffff, 4'b0011);
        do_read (24'd24, 4'b1111, 32'h0000_ffff);
        do_write(24'd24, 32'habcd_12ff, 4'b1111);
        do_read (24'd24, 4'b1000, 32'h0000_00ab);
        do_read (24'd24, 4'b0100, 32'h0000_00cd);
        do_read (24'd24, 4'b0010, 32'h0000_0012);
        do_read (24'd24, 4'b0001, 32'h0000_00ff);
        do_read (24'd24, 4'b0101, 32'h0000_cdff);
        do_read (24'd24, 4'b0000, 32'h0000_0000);

        do_read (24'd25, 4'b0001, 32'h0000_0012);
        do_read (24'd26, 4'b0001, 32'h0000_00cd);
        do_read (24'd27, 4'b0001, 32'h0000_00ab);
        do_read (24'd25, 4'b1111, 32'h00ab_cd12);

        do_write(24'(MEM_BYTES - 2), 32'h4433_2211, 4'b1111);
        do_read (24'd0, 4'b0011, 32'h0000_4433);
        do_read (24'(MEM_BYTES - 2), 4'b1111, 32'h4433_2211);
        do_read (24'(MEM_BYTES + 24), 4'b1111, 32'habcd_12ff);

        // Read and write together: write commits, readdata keeps the last read.
        @(negedge clk);
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        bus.addr       = 24'd40;
        bus.writedata  = 32'h5566_7788;
        bus.byteenable = 4'b1111;
        complete();
        check("rw_readdata_hold", bus.readdata, 32'habcd_12ff);
        do_read(24'd40, 4'b1111, 32'h5566_7788);

        // Asynchronous reset between edges clears readdata immediately.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_readdata", bus.readdata, 32'h0);
        check("async_reset_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
        #1 reset = 1'b0;
        do_read(24'd24, 4'b1111, 32'habcd_12ff);
        do_read(24'd40, 4'b1111, 32'h5566_7788);

        repeat (2) @(posedge clk);
        check("reads_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
